// File: rtl/router_fsm_np.sv
`default_nettype none
// ============================================================================
//  Module   : router_fsm_np
//  Purpose  : Packet-router control FSM. Decodes the header address of each
//             packet, waits (bounded) for the destination FIFO to drain,
//             steers payload / parity writes, handles FIFO-full back-pressure
//             and discards packets with an illegal or starved destination.
//  Ports    : clock_i, reset_i           - clock, synchronous active-high reset
//             pkt_valid_i, data_in_i     - source valid, header address bits
//             soft_reset_i, fifo_empty_i - per-port FIFO status
//             fifo_full_i                - full flag of selected FIFO
//             low_pkt_valid_i, parity_done_i - register-block flags
//             *_state_o / detect_add_o / rst_int_reg_o / drop_pkt_o - decodes
//             write_enb_reg_o, busy_o    - FIFO write enable, source stall
//             dest_sel_o, drop_count_o   - latched destination, drop counter
//  Revision : 1.0 - initial release
// ============================================================================
module router_fsm_np #(
    parameter int NUM_PORTS    = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 32
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 pkt_valid_i,
    input  logic [ADDR_W-1:0]    data_in_i,
    input  logic [NUM_PORTS-1:0] soft_reset_i,
    input  logic [NUM_PORTS-1:0] fifo_empty_i,
    input  logic                 fifo_full_i,
    input  logic                 low_pkt_valid_i,
    input  logic                 parity_done_i,
    output logic                 detect_add_o,
    output logic                 lfd_state_o,
    output logic                 ld_state_o,
    output logic                 full_state_o,
    output logic                 laf_state_o,
    output logic                 rst_int_reg_o,
    output logic                 write_enb_reg_o,
    output logic                 busy_o,
    output logic                 drop_pkt_o,
    output logic [ADDR_W-1:0]    dest_sel_o,
    output logic [7:0]           drop_count_o
);

    localparam int          c_NSEL      = 1 << ADDR_W;
    localparam logic [7:0]  c_WAIT_LAST = 8'(WAIT_TIMEOUT - 1);
    localparam logic [ADDR_W:0] c_NUM_PORTS = (ADDR_W + 1)'(NUM_PORTS);

    typedef enum logic [3:0] {
        S_DECODE = 4'd0,
        S_LFD    = 4'd1,
        S_LD     = 4'd2,
        S_FULL   = 4'd3,
        S_LAF    = 4'd4,
        S_LP     = 4'd5,
        S_CHK    = 4'd6,
        S_WAIT   = 4'd7,
        S_DROP   = 4'd8
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   dest_sel_q, dest_sel_d;
    logic [7:0]          wait_cnt_q, wait_cnt_d;
    logic [7:0]          drop_count_q;
    logic                detect_add_q, lfd_q, ld_q, full_q, laf_q, rst_int_q;
    logic                write_enb_q, busy_q, drop_q;

    // Status vectors widened to the full address space so that addresses
    // beyond NUM_PORTS select a constant 0 instead of an out-of-range bit.
    logic [c_NSEL-1:0]   w_empty_sel;
    logic [c_NSEL-1:0]   w_soft_sel;
    logic                w_addr_ok;

    generate
        for (genvar i = 0; i < c_NSEL; i++) begin : g_pad
            if (i < NUM_PORTS) begin : g_real
                assign w_empty_sel[i] = fifo_empty_i[i];
                assign w_soft_sel[i]  = soft_reset_i[i];
            end else begin : g_none
                assign w_empty_sel[i] = 1'b0;
                assign w_soft_sel[i]  = 1'b0;
            end
        end
    endgenerate

    assign w_addr_ok = ({1'b0, data_in_i} < c_NUM_PORTS);

    always_comb begin
        state_d    = state_q;
        dest_sel_d = dest_sel_q;
        wait_cnt_d = 8'd0;   // only a stay in WAIT keeps a non-zero count
        case (state_q)
            S_DECODE: begin
                if (pkt_valid_i) begin
                    dest_sel_d = data_in_i;
                    if (!w_addr_ok)
                        state_d = S_DROP;
                    else if (w_empty_sel[data_in_i])
                        state_d = S_LFD;
                    else
                        state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Draining beats timing out when both happen together.
                if (w_empty_sel[dest_sel_q])
                    state_d = S_LFD;
                else if (wait_cnt_q == c_WAIT_LAST)
                    state_d = S_DROP;
                else
                    wait_cnt_d = wait_cnt_q + 8'd1;
            end
            S_LFD:  state_d = S_LD;
            S_LD: begin
                if (fifo_full_i)
                    state_d = S_FULL;
                else if (!pkt_valid_i)
                    state_d = S_LP;
            end
            S_FULL: begin
                if (!fifo_full_i)
                    state_d = S_LAF;
            end
            S_LAF: begin
                if (parity_done_i)
                    state_d = S_DECODE;
                else if (low_pkt_valid_i)
                    state_d = S_LP;
                else
                    state_d = S_LD;
            end
            S_LP:   state_d = S_CHK;
            S_CHK:  state_d = fifo_full_i ? S_FULL : S_DECODE;
            S_DROP: begin
                if (!pkt_valid_i)
                    state_d = S_DECODE;
            end
            default: state_d = S_DECODE;
        endcase

        // Soft reset of the selected port aborts the packet from any state
        // past header decode.
        if (state_q != S_DECODE && w_soft_sel[dest_sel_q]) begin
            state_d    = S_DECODE;
            wait_cnt_d = 8'd0;
        end
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= S_DECODE;
            dest_sel_q   <= '0;
            wait_cnt_q   <= 8'd0;
            drop_count_q <= 8'd0;
            detect_add_q <= 1'b1;
            lfd_q        <= 1'b0;
            ld_q         <= 1'b0;
            full_q       <= 1'b0;
            laf_q        <= 1'b0;
            rst_int_q    <= 1'b0;
            write_enb_q  <= 1'b0;
            busy_q       <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            dest_sel_q <= dest_sel_d;
            wait_cnt_q <= wait_cnt_d;
            if (state_d == S_DROP && state_q != S_DROP && drop_count_q != 8'hFF)
                drop_count_q <= drop_count_q + 8'd1;
            detect_add_q <= (state_d == S_DECODE);
            lfd_q        <= (state_d == S_LFD);
            ld_q         <= (state_d == S_LD);
            full_q       <= (state_d == S_FULL);
            laf_q        <= (state_d == S_LAF);
            rst_int_q    <= (state_d == S_CHK);
            write_enb_q  <= (state_d == S_LD) || (state_d == S_LAF) || (state_d == S_LP);
            busy_q       <= (state_d == S_LFD) || (state_d == S_FULL) || (state_d == S_LAF) ||
                            (state_d == S_LP)  || (state_d == S_CHK)  || (state_d == S_WAIT);
            drop_q       <= (state_d == S_DROP);
        end
    end

    assign detect_add_o    = detect_add_q;
    assign lfd_state_o     = lfd_q;
    assign ld_state_o      = ld_q;
    assign full_state_o    = full_q;
    assign laf_state_o     = laf_q;
    assign rst_int_reg_o   = rst_int_q;
    assign write_enb_reg_o = write_enb_q;
    assign busy_o          = busy_q;
    assign drop_pkt_o      = drop_q;
    assign dest_sel_o      = dest_sel_q;
    assign drop_count_o    = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_router_fsm_np.sv
`default_nettype none
// ============================================================================
//  Module   : tb_router_fsm_np
//  Purpose  : Self-checking bench for router_fsm_np: directed vector table,
//             hand-written corner sequences and randomized traffic checked
//             against a behavioural model of the packet-handling rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_router_fsm_np;

    localparam int NP = 3;
    localparam int AW = 2;
    localparam int TO = 32;

    // Expected output vectors {detect,lfd,ld,full,laf,rst_int,we,busy,drop}
    localparam logic [8:0] E_DEC  = 9'b1_0_0_0_0_0_0_0_0;
    localparam logic [8:0] E_LFD  = 9'b0_1_0_0_0_0_0_1_0;
    localparam logic [8:0] E_LD   = 9'b0_0_1_0_0_0_1_0_0;
    localparam logic [8:0] E_FULL = 9'b0_0_0_1_0_0_0_1_0;
    localparam logic [8:0] E_LAF  = 9'b0_0_0_0_1_0_1_1_0;
    localparam logic [8:0] E_LP   = 9'b0_0_0_0_0_0_1_1_0;
    localparam logic [8:0] E_CHK  = 9'b0_0_0_0_0_1_0_1_0;
    localparam logic [8:0] E_WAIT = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] E_DROP = 9'b0_0_0_0_0_0_0_0_1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, pv, full, low, par;
    logic [AW-1:0] din;
    logic [NP-1:0] sr, emp;
    logic          detect_add, lfd, ld, full_st, laf, rst_int, we, busy, drop;
    logic [AW-1:0] dest_sel;
    logic [7:0]    drop_count;

    router_fsm_np #(.NUM_PORTS(NP), .ADDR_W(AW), .WAIT_TIMEOUT(TO)) dut (
        .clock_i(clk), .reset_i(rst), .pkt_valid_i(pv), .data_in_i(din),
        .soft_reset_i(sr), .fifo_empty_i(emp), .fifo_full_i(full),
        .low_pkt_valid_i(low), .parity_done_i(par),
        .detect_add_o(detect_add), .lfd_state_o(lfd), .ld_state_o(ld),
        .full_state_o(full_st), .laf_state_o(laf), .rst_int_reg_o(rst_int),
        .write_enb_reg_o(we), .busy_o(busy), .drop_pkt_o(drop),
        .dest_sel_o(dest_sel), .drop_count_o(drop_count)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_FIRST, M_PAY, M_STALL, M_RESUME, M_PAR, M_CHECK, M_HOLD, M_DISCARD} mst_e;
    mst_e mstate = M_IDLE;
    int   mdest  = 0;
    int   mwait  = 0;
    int   mdrops = 0;

    function automatic logic [8:0] code_of(mst_e s);
        case (s)
            M_IDLE:    return E_DEC;
            M_FIRST:   return E_LFD;
            M_PAY:     return E_LD;
            M_STALL:   return E_FULL;
            M_RESUME:  return E_LAF;
            M_PAR:     return E_LP;
            M_CHECK:   return E_CHK;
            M_HOLD:    return E_WAIT;
            default:   return E_DROP;
        endcase
    endfunction

    function automatic logic [8:0] outs();
        return {detect_add, lfd, ld, full_st, laf, rst_int, we, busy, drop};
    endfunction

    task automatic model_step();
        mst_e prev;
        int   d;
        if (rst) begin
            mstate = M_IDLE; mdest = 0; mwait = 0; mdrops = 0;
            return;
        end
        prev = mstate;
        if (mstate != M_IDLE && mdest < NP && sr[mdest]) begin
            mstate = M_IDLE;
            mwait  = 0;
        end else begin
            case (mstate)
                M_IDLE: if (pv) begin
                    d = int'(din);
                    mdest = d;
                    mwait = 0;
                    if (d >= NP)      mstate = M_DISCARD;
                    else if (emp[d])  mstate = M_FIRST;
                    else              mstate = M_HOLD;
                end
                M_HOLD: begin
                    if (emp[mdest])          begin mstate = M_FIRST;   mwait = 0; end
                    else if (mwait == TO-1)  begin mstate = M_DISCARD; mwait = 0; end
                    else                     mwait = mwait + 1;
                end
                M_FIRST:  mstate = M_PAY;
                M_PAY:    if (full) mstate = M_STALL; else if (!pv) mstate = M_PAR;
                M_STALL:  if (!full) mstate = M_RESUME;
                M_RESUME: mstate = par ? M_IDLE : (low ? M_PAR : M_PAY);
                M_PAR:    mstate = M_CHECK;
                M_CHECK:  mstate = full ? M_STALL : M_IDLE;
                M_DISCARD: if (!pv) mstate = M_IDLE;
                default:  mstate = M_IDLE;
            endcase
        end
        if (mstate == M_DISCARD && prev != M_DISCARD && mdrops < 255)
            mdrops = mdrops + 1;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check9(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: outputs got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkv(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: model sees the same inputs as the DUT, compare #1 after edge.
    task automatic tick(input string name);
        @(posedge clk);
        model_step();
        #1;
        check9(name, outs(), code_of(mstate));
        checkv({name, "_dest"}, int'(dest_sel), mdest);
        checkv({name, "_drops"}, int'(drop_count), mdrops);
    endtask

    task automatic drive(input logic p, input logic [AW-1:0] d, input logic [NP-1:0] s,
                         input logic [NP-1:0] e, input logic f, input logic l, input logic pd);
        pv = p; din = d; sr = s; emp = e; full = f; low = l; par = pd;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          p;
        logic [AW-1:0] d;
        logic [NP-1:0] e;
        logic          f;
        logic          l;
        logic [8:0]    exp;
        logic [AW-1:0] edest;
    } vec_t;

    vec_t tv[17];
    int   n;

    initial begin
        // Nominal packet to port 1, then a packet to port 0 with back-pressure.
        tv[0]  = '{1'b1, 2'd1, 3'b111, 1'b0, 1'b0, E_LFD,  2'd1};
        tv[1]  = '{1'b1, 2'd1, 3'b111, 1'b0, 1'b0, E_LD,   2'd1};
        tv[2]  = '{1'b1, 2'd1, 3'b111, 1'b0, 1'b0, E_LD,   2'd1};
        tv[3]  = '{1'b1, 2'd1, 3'b111, 1'b0, 1'b0, E_LD,   2'd1};
        tv[4]  = '{1'b1, 2'd1, 3'b111, 1'b0, 1'b0, E_LD,   2'd1};
        tv[5]  = '{1'b0, 2'd1, 3'b111, 1'b0, 1'b0, E_LP,   2'd1};
        tv[6]  = '{1'b0, 2'd1, 3'b111, 1'b0, 1'b0, E_CHK,  2'd1};
        tv[7]  = '{1'b0, 2'd1, 3'b111, 1'b0, 1'b0, E_DEC,  2'd1};
        tv[8]  = '{1'b1, 2'd0, 3'b111, 1'b0, 1'b0, E_LFD,  2'd0};
        tv[9]  = '{1'b1, 2'd0, 3'b111, 1'b0, 1'b0, E_LD,   2'd0};
        tv[10] = '{1'b1, 2'd0, 3'b111, 1'b1, 1'b0, E_FULL, 2'd0};
        tv[11] = '{1'b1, 2'd0, 3'b111, 1'b1, 1'b0, E_FULL, 2'd0};
        tv[12] = '{1'b1, 2'd0, 3'b111, 1'b1, 1'b0, E_FULL, 2'd0};
        tv[13] = '{1'b0, 2'd0, 3'b111, 1'b0, 1'b1, E_LAF,  2'd0};
        tv[14] = '{1'b0, 2'd0, 3'b111, 1'b0, 1'b1, E_LP,   2'd0};
        tv[15] = '{1'b0, 2'd0, 3'b111, 1'b0, 1'b0, E_CHK,  2'd0};
        tv[16] = '{1'b0, 2'd0, 3'b111, 1'b0, 1'b0, E_DEC,  2'd0};

        // Reset
        rst = 1'b1;
        drive(1'b0, 2'd0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        tick("reset");
        check9("reset_outs", outs(), E_DEC);
        checkv("reset_dest", int'(dest_sel), 0);
        checkv("reset_drops", int'(drop_count), 0);
        rst = 1'b0;

        // Table-driven packets
        for (int i = 0; i < 17; i++) begin
            drive(tv[i].p, tv[i].d, 3'b000, tv[i].e, tv[i].f, tv[i].l, 1'b0);
            tick("tv");
            check9($sformatf("tv%0d", i), outs(), tv[i].exp);
            checkv($sformatf("tv%0d_dest", i), int'(dest_sel), int'(tv[i].edest));
        end

        // Illegal destination: 6-cycle packet discarded
        n = 0;
        drive(1'b1, 2'd3, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick("drop6");
            if (outs() == E_DROP) n++;
        end
        pv = 1'b0;
        tick("drop6_end");
        checkv("drop6_cycles", n, 6);
        checkv("drop6_count", int'(drop_count), 1);
        check9("drop6_idle", outs(), E_DEC);

        // Starved destination: timeout after exactly TO cycles in WAIT
        n = 0;
        drive(1'b1, 2'd2, 3'b000, 3'b011, 1'b0, 1'b0, 1'b0);
        tick("wait_entry");
        if (outs() == E_WAIT) n++;
        pv = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick("wait_to");
            if (outs() == E_WAIT) n++;
            else break;
        end
        checkv("wait_cycles", n, TO);
        check9("wait_timeout_drop", outs(), E_DROP);
        checkv("wait_timeout_count", int'(drop_count), 2);
        tick("wait_to_exit");

        // FIFO drains on the 10th wait cycle
        drive(1'b1, 2'd2, 3'b000, 3'b011, 1'b0, 1'b0, 1'b0);
        tick("drain_entry");
        pv = 1'b0;
        for (int k = 0; k < 9; k++) tick("drain_wait");
        emp = 3'b111;
        tick("drain_lfd");
        check9("drain_lfd_state", outs(), E_LFD);
        checkv("drain_no_drop", int'(drop_count), 2);
        for (int k = 0; k < 4; k++) tick("drain_finish");

        // Drain and timeout in the same cycle: drain wins
        drive(1'b1, 2'd2, 3'b000, 3'b011, 1'b0, 1'b0, 1'b0);
        tick("tie_entry");
        pv = 1'b0;
        for (int k = 0; k < TO-1; k++) tick("tie_wait");
        check9("tie_still_wait", outs(), E_WAIT);
        emp = 3'b111;
        tick("tie_lfd");
        check9("tie_lfd_state", outs(), E_LFD);
        checkv("tie_no_drop", int'(drop_count), 2);
        for (int k = 0; k < 4; k++) tick("tie_finish");

        // Soft reset: only the selected port matters
        drive(1'b1, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0);
        tick("sr_lfd");
        tick("sr_ld");
        sr = 3'b010;
        tick("sr_other");
        check9("sr_other_port", outs(), E_LD);
        sr = 3'b001;
        tick("sr_own");
        check9("sr_own_port", outs(), E_DEC);
        drive(1'b1, 2'd1, 3'b111, 3'b111, 1'b0, 1'b0, 1'b0);
        tick("sr_in_decode");
        check9("sr_ignored_decode", outs(), E_LFD);
        drive(1'b0, 2'd1, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) tick("sr_finish");

        // Drop counter saturation
        rst = 1'b1;
        tick("sat_reset");
        rst = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            drive(1'b1, 2'd3, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0);
            tick("sat_drop");
            pv = 1'b0;
            tick("sat_idle");
            if (k == 1)   checkv("sat_first",  int'(drop_count), 1);
            if (k == 255) checkv("sat_255th",  int'(drop_count), 255);
            if (k == 256) checkv("sat_256th",  int'(drop_count), 255);
        end

        // Reset in the middle of a payload
        drive(1'b1, 2'd1, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0);
        tick("mid_lfd");
        tick("mid_ld");
        check9("mid_in_ld", outs(), E_LD);
        rst = 1'b1;
        tick("mid_reset");
        check9("mid_reset_outs", outs(), E_DEC);
        checkv("mid_reset_drops", int'(drop_count), 0);
        checkv("mid_reset_dest", int'(dest_sel), 0);
        rst = 1'b0;

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            rst  = ($urandom_range(0, 499) == 0);
            pv   = ($urandom_range(0, 9) < 7);
            din  = AW'($urandom);
            sr   = ($urandom_range(0, 39) == 0) ? NP'($urandom) : '0;
            emp  = ($urandom_range(0, 2) == 0) ? NP'($urandom) : 3'b111;
            full = ($urandom_range(0, 3) == 0);
            low  = $urandom_range(0, 1) == 1;
            par  = ($urandom_range(0, 3) == 0);
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
